car_motion_controller: RTL



---
 rtl/car_motion_controller.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/car_motion_controller.sv
// Car sprite motion for the four traffic lanes: moves cars once per frame
// (or per FRAME_DIV frames) during vertical blanking and flags frog/car overlap.
module car_motion_controller #(
   parameter int         TILE_SIZE      = 32,
   parameter int         H_VISIBLE_AREA = 640,
   parameter int         FRAME_DIV      = 1,
   parameter logic [8:0] LANE_Y_0       = 9'd128,
   parameter logic [8:0] LANE_Y_1       = 9'd192,
   parameter logic [8:0] LANE_Y_2       = 9'd256,
   parameter logic [8:0] LANE_Y_3       = 9'd320,
   parameter logic [9:0] INIT_X_0       = 10'd0,
   parameter logic [9:0] INIT_X_1       = 10'd160,
   parameter logic [9:0] INIT_X_2       = 10'd320,
   parameter logic [9:0] INIT_X_3       = 10'd480,
   parameter logic [3:0] LANE_SPEED_0   = 4'd1,
   parameter logic [3:0] LANE_SPEED_1   = 4'd2,
   parameter logic [3:0] LANE_SPEED_2   = 4'd1,
   parameter logic [3:0] LANE_SPEED_3   = 4'd3
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_VGA_VSync,
   input  logic       i_Enable,
   input  logic       i_Restart,
   input  logic       i_Level_Up,
   input  logic [9:0] i_Frog_X,
   input  logic [9:0] i_Frog_Y,
   output logic [9:0] o_Car_1X_Position,
   output logic [9:0] o_Car_2X_Position,
   output logic [9:0] o_Car_3X_Position,
   output logic [9:0] o_Car_4X_Position,
   output logic [8:0] o_Car_1Y_Position,
   output logic [8:0] o_Car_2Y_Position,
   output logic [8:0] o_Car_3Y_Position,
   output logic [8:0] o_Car_4Y_Position,
   output logic       o_Collision,
   output logic [2:0] o_Level
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_MOVE  = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   localparam logic [10:0] H_W      = 11'(H_VISIBLE_AREA);
   localparam logic [10:0] TILE     = 11'(TILE_SIZE);
   localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);

   state_t     state_r;
   state_t     state_s;
   logic       vs_meta_r;
   logic       vs_sync_r;
   logic       vs_prev_r;
   logic       tick_r;
   logic [3:0] div_r;
   logic [2:0] level_r;
   logic [2:0] move_level_r;
   logic [1:0] lane_r;
   logic [9:0] car_x_r [4];
   logic [8:0] car_y_s [4];
   logic       collision_r;
   logic       step_issue_s;
   logic       enter_move_s;
   logic [3:0] step_s;
   logic       any_hit_s;

   function automatic logic [9:0] init_x(input logic [1:0] idx);
      case (idx)
         2'd0:    init_x = INIT_X_0;
         2'd1:    init_x = INIT_X_1;
         2'd2:    init_x = INIT_X_2;
         default: init_x = INIT_X_3;
      endcase
   endfunction

   function automatic logic [3:0] lane_speed(input logic [1:0] idx);
      case (idx)
         2'd0:    lane_speed = LANE_SPEED_0;
         2'd1:    lane_speed = LANE_SPEED_1;
         2'd2:    lane_speed = LANE_SPEED_2;
         default: lane_speed = LANE_SPEED_3;
      endcase
   endfunction

   // Even lanes move right, odd lanes move left; both wrap at the visible width.
   function automatic logic [9:0] move_x(input logic [9:0] x, input logic [3:0] step,
                                         input logic right);
      logic [10:0] x11;
      logic [10:0] s11;
      logic [10:0] res;
      x11 = {1'b0, x};
      s11 = {7'd0, step};
      if (right) begin
         res = x11 + s11;
         if (res >= H_W) begin
            res = res - H_W;
         end else begin
            res = res;
         end
      end else begin
         if (x11 < s11) begin
            res = x11 + H_W - s11;
         end else begin
            res = x11 - s11;
         end
      end
      return 10'(res);
   endfunction

   function automatic logic overlap(input logic [9:0] fx, input logic [9:0] fy,
                                    input logic [9:0] cx, input logic [8:0] cy);
      logic [10:0] fx11;
      logic [10:0] fy11;
      logic [10:0] cx11;
      logic [10:0] cy11;
      fx11 = {1'b0, fx};
      fy11 = {1'b0, fy};
      cx11 = {1'b0, cx};
      cy11 = {2'b00, cy};
      return (fx11 < cx11 + TILE) && (cx11 < fx11 + TILE) &&
             (fy11 < cy11 + TILE) && (cy11 < fy11 + TILE);
   endfunction

   assign car_y_s[0] = LANE_Y_0;
   assign car_y_s[1] = LANE_Y_1;
   assign car_y_s[2] = LANE_Y_2;
   assign car_y_s[3] = LANE_Y_3;

   assign step_issue_s = (state_r == S_WAIT) && tick_r && (div_r == DIV_LAST);
   assign enter_move_s = step_issue_s && i_Enable;
   assign step_s       = lane_speed(lane_r) + {1'b0, move_level_r};

   // VSync synchroniser and registered falling-edge frame tick
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         vs_meta_r <= 1'b1;
         vs_sync_r <= 1'b1;
         vs_prev_r <= 1'b1;
         tick_r    <= 1'b0;
      end else begin
         vs_meta_r <= i_VGA_VSync;
         vs_sync_r <= vs_meta_r;
         vs_prev_r <= vs_sync_r;
         tick_r    <= vs_prev_r & ~vs_sync_r;
      end
   end

   // FSM state register
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; a started move sequence always runs to completion
   always_comb begin
      state_s = state_r;
      if (i_Restart) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE:  state_s = i_Enable ? S_WAIT : S_IDLE;
            S_WAIT: begin
               if (!i_Enable) begin
                  state_s = S_IDLE;
               end else if (step_issue_s) begin
                  state_s = S_MOVE;
               end else begin
                  state_s = S_WAIT;
               end
            end
            S_MOVE:  state_s = (lane_r == 2'd3) ? S_CHECK : S_MOVE;
            S_CHECK: state_s = i_Enable ? S_WAIT : S_IDLE;
            default: state_s = S_IDLE;
         endcase
      end
   end

   // Frame divider, level counter and lane sequencing
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         div_r        <= 4'd0;
         level_r      <= 3'd0;
         move_level_r <= 3'd0;
         lane_r       <= 2'd0;
      end else if (i_Restart) begin
         div_r        <= 4'd0;
         level_r      <= 3'd0;
         move_level_r <= 3'd0;
         lane_r       <= 2'd0;
      end else begin
         if ((state_r == S_WAIT) && tick_r) begin
            div_r <= (div_r == DIV_LAST) ? 4'd0 : div_r + 4'd1;
         end
         if (i_Level_Up && (level_r != 3'd7)) begin
            level_r <= level_r + 3'd1;
         end
         // Level is frozen for the whole sequence so all lanes use the same value
         if (enter_move_s) begin
            move_level_r <= level_r;
            lane_r       <= 2'd0;
         end else if (state_r == S_MOVE) begin
            lane_r <= lane_r + 2'd1;
         end
      end
   end

   // Car X positions, one lane per cycle while moving
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         for (int i = 0; i < 4; i++) car_x_r[i] <= init_x(2'(i));
      end else if (i_Restart) begin
         for (int i = 0; i < 4; i++) car_x_r[i] <= init_x(2'(i));
      end else if (state_r == S_MOVE) begin
         car_x_r[lane_r] <= move_x(car_x_r[lane_r], step_s, ~lane_r[0]);
      end
   end

   // Overlap of the frog against every car
   always_comb begin
      any_hit_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         any_hit_s = any_hit_s | overlap(i_Frog_X, i_Frog_Y, car_x_r[i], car_y_s[i]);
      end
   end

   // Collision pulse, raised for the cycle after the check state
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         collision_r <= 1'b0;
      end else if (i_Restart) begin
         collision_r <= 1'b0;
      end else begin
         collision_r <= (state_r == S_CHECK) && any_hit_s;
      end
   end

   assign o_Car_1X_Position = car_x_r[0];
   assign o_Car_2X_Position = car_x_r[1];
   assign o_Car_3X_Position = car_x_r[2];
   assign o_Car_4X_Position = car_x_r[3];
   assign o_Car_1Y_Position = car_y_s[0];
   assign o_Car_2Y_Position = car_y_s[1];
   assign o_Car_3Y_Position = car_y_s[2];
   assign o_Car_4Y_Position = car_y_s[3];
   assign o_Collision       = collision_r;
   assign o_Level           = level_r;

endmodule
